// File: rtl/slot_pkg.sv
// Shared types and constants for the slot reel datapath: stop encodings,
// spinner state encoding and the LFSR polynomial used by all randomisers.
package slot_pkg;

    localparam int          NUM_P_STOPS = 32;
    localparam logic [15:0] LFSR_MASK   = 16'hB400;

    typedef logic [5:0] v_stop_t;
    typedef logic [4:0] p_stop_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPIN,
        ST_SETTLE,
        ST_DONE
    } spin_state_t;

    // Physical stops form a ring; the 5-bit add wraps 31 back to 0.
    function automatic p_stop_t next_stop(input p_stop_t p);
        return p + 5'd1;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (right-shifting), shared by reel spinners
// and the payout randomiser.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] MASK = 16'hB400
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (q[0]) begin
            q <= (q >> 1) ^ MASK;
        end else begin
            q <= q >> 1;
        end
    end

endmodule

// File: rtl/reel_spinner.sv
// Per-reel spin controller: draws a random virtual stop, spins the displayed
// position for a minimum number of steps, then decelerates onto the mapped stop.
module reel_spinner
    import slot_pkg::*;
#(
    parameter int          MIN_SPIN_STEPS = 64,
    parameter int          STEP_DIV       = 2,
    parameter int          SETTLE_DIV     = 4,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    output logic [5:0] v_reel,
    input  logic [4:0] p_target,
    output logic [4:0] position,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] STEP_LAST   = 4'(STEP_DIV - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_DIV - 1);
    localparam logic [9:0] MIN_STEPS   = 10'(MIN_SPIN_STEPS);

    logic [15:0] lfsr_q;
    logic        unused_lfsr_bits;

    spin_state_t state, state_nxt;
    logic [3:0]  div_cnt, div_cnt_nxt;
    logic [9:0]  step_cnt, step_cnt_nxt;
    p_stop_t     target, target_nxt;
    p_stop_t     pos_nxt;
    v_stop_t     v_reel_nxt;
    logic        busy_nxt, done_nxt;

    lfsr16 #(
        .SEED (LFSR_SEED),
        .MASK (LFSR_MASK)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr_q)
    );

    // Only the low six bits feed the virtual stop draw.
    assign unused_lfsr_bits = ^lfsr_q[15:6];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            div_cnt  <= '0;
            step_cnt <= '0;
            target   <= '0;
            position <= '0;
            v_reel   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_cnt_nxt;
            step_cnt <= step_cnt_nxt;
            target   <= target_nxt;
            position <= pos_nxt;
            v_reel   <= v_reel_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        div_cnt_nxt  = div_cnt;
        step_cnt_nxt = step_cnt;
        target_nxt   = target;
        pos_nxt      = position;
        v_reel_nxt   = v_reel;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    v_reel_nxt   = lfsr_q[5:0];
                    div_cnt_nxt  = '0;
                    step_cnt_nxt = '0;
                    state_nxt    = ST_SPIN;
                end
            end
            ST_SPIN: begin
                if (tick) begin
                    if (div_cnt == STEP_LAST) begin
                        div_cnt_nxt  = '0;
                        pos_nxt      = next_stop(position);
                        step_cnt_nxt = step_cnt + 10'd1;
                        if (step_cnt + 10'd1 == MIN_STEPS) begin
                            target_nxt = p_target;
                            state_nxt  = ST_SETTLE;
                        end
                    end else begin
                        div_cnt_nxt = div_cnt + 4'd1;
                    end
                end
            end
            ST_SETTLE: begin
                // Equality here is only possible on entry; later steps exit on landing.
                if (position == target) begin
                    state_nxt = ST_DONE;
                end else if (tick) begin
                    if (div_cnt == SETTLE_LAST) begin
                        div_cnt_nxt = '0;
                        pos_nxt     = next_stop(position);
                        if (next_stop(position) == target) begin
                            state_nxt = ST_DONE;
                        end
                    end else begin
                        div_cnt_nxt = div_cnt + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt == ST_SPIN) || (state_nxt == ST_SETTLE);
        done_nxt = (state_nxt == ST_DONE);
    end

endmodule
